reg_wb_arbiter: RTL
===================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning port-B buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles of A-grant with B pending before B is forced.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port a_valid  in  1  pipeline writeback request.
REQ-006 SHALL have port a_addr  in  5  pipeline destination register.
REQ-007 SHALL have port a_data  in  32  pipeline writeback data.
REQ-008 SHALL have port a_link  in  1  jump-and-link writeback; destination is r31 regardless of a_addr.
REQ-009 SHALL have port a_stall  out  1  pipeline writeback not accepted this cycle; A holds its request.
REQ-010 SHALL have port b_valid  in  1  multi-cycle unit result valid.
REQ-011 SHALL have port b_ready  out  1  buffer can accept; transfer when b_valid & b_ready.
REQ-012 SHALL have port b_addr  in  5  multi-cycle unit destination register.
REQ-013 SHALL have port b_data  in  32  multi-cycle unit result.
REQ-014 SHALL have ports rf_wr_en 1, rf_jal 1, rf_wr_addr 5, rf_wr_data 32, rf_link_addr 32  out  register-file write port.
REQ-015 SHALL have ports chk_addr0, chk_addr1  in  5 and hazard0, hazard1  out  1  issue-stage pending-write query.

Function
REQ-016 SHALL buffer accepted B transfers in a DEPTH-entry FIFO; b_ready = not full (no same-cycle pop pass-through).
REQ-017 SHALL discard accepted B transfers with b_addr = 0 (not pushed, no write).
REQ-018 SHALL not write a B entry in its push cycle; earliest write is the next cycle.
REQ-019 SHALL treat A as "effective" when a_valid & (a_link | a_addr != 0); ineffective A is dropped and does not occupy the port.
REQ-020 SHALL grant per cycle: state FORCE with FIFO non-empty -> B; else effective A -> A; else FIFO non-empty -> B; else none.
REQ-021 SHALL on A grant drive rf_wr_en=1, rf_wr_addr=a_addr, rf_wr_data=a_data, rf_jal=a_link, rf_link_addr=a_data.
REQ-022 SHALL on B grant drive rf_wr_en=1, rf_jal=0, rf_wr_addr/rf_wr_data = FIFO head, and pop the head; with no grant, rf_wr_en=0 and rf_jal=0.
REQ-023 SHALL compute write outputs combinationally from current inputs and registered state (zero-cycle latency for A).
REQ-024 SHALL run a 2-state FSM: NORMAL, FORCE.
REQ-025 SHALL keep starve counter cnt: increment on A grant with FIFO non-empty; clear on B grant or FIFO empty.
REQ-026 SHALL transition NORMAL->FORCE when cnt reaches STARVE_LIMIT; FORCE->NORMAL after exactly one B grant (cnt cleared).
REQ-027 SHALL assert a_stall = (state==FORCE) & a_valid & effective; A's request is not written that cycle.
REQ-028 SHALL set hazardN = chk_addrN != 0 and equals the address of any valid FIFO entry; incoming same-cycle push not included.
REQ-029 SHALL handle simultaneous push and pop correctly (occupancy unchanged, ordering preserved, pointers wrap modulo DEPTH).
REQ-030 SHALL never write r0; B entries are written in arrival order.

Reset
REQ-031 SHALL, while rst=0, force FIFO empty, pointers 0, cnt=0, state NORMAL, b_ready=0, a_stall=0, rf_wr_en=0, rf_jal=0, hazard0/1=0, rf_wr_addr=0, rf_wr_data=0, rf_link_addr=0.
REQ-032 SHALL, on reset assertion mid-operation, discard all buffered B entries immediately and asynchronously.
REQ-033 SHALL drive b_ready=1 in the first cycle after rst deasserts.

Verification
REQ-034 Bench SHALL check: A only, a_addr=5, a_data=0xDEADBEEF -> same cycle rf_wr_en=1, addr 5, data 0xDEADBEEF.
REQ-035 Bench SHALL check: a_link=1, a_addr=7, a_data=0x00400010 -> rf_jal=1, rf_link_addr=0x00400010; with a_addr=0 and a_link=0 -> rf_wr_en=0.
REQ-036 Bench SHALL check: push 4 B entries (r1..r4) with A continuously valid -> b_ready=0 after the 4th push; hazard0=1 for chk_addr0=3; after STARVE_LIMIT=4 A grants -> a_stall=1 for one cycle and r1 written.
REQ-037 Bench SHALL check: A idle, B pushes r9=0x1234 -> write of r9 one cycle later; b_addr=0 push -> no write, FIFO unchanged.
REQ-038 Bench SHALL check: FIFO full with simultaneous pop and new push -> occupancy stays 4, subsequent writes in order.
REQ-039 Bench SHALL check: rst=0 with 3 entries buffered -> immediately rf_wr_en=0, hazards 0; after release, no stale writes occur.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: pipeline port A (zero latency) shares the write
// port with a buffered multi-cycle port B; a starvation counter forces B after STARVE_LIMIT.
module reg_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        a_link,
    output logic        a_stall,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        rf_wr_en,
    output logic        rf_jal,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic [31:0] rf_link_addr,
    input  logic [4:0]  chk_addr0,
    input  logic [4:0]  chk_addr1,
    output logic        hazard0,
    output logic        hazard1
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic { ST_NORMAL = 1'b0, ST_FORCE = 1'b1 } state_t;

    entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic [SW-1:0]      cnt;
    state_t             state;

    logic   empty, full, a_eff, force_b, grant_a, grant_b, push;
    entry_t head;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign a_eff   = a_valid & (a_link | (a_addr != 5'd0));
    assign force_b = (state == ST_FORCE) & ~empty;
    assign grant_b = rst & ~empty & (force_b | ~a_eff);
    assign grant_a = rst & a_eff & ~force_b;
    assign a_stall = rst & a_eff & force_b;
    assign b_ready = rst & ~full;
    // r0 writes from B are swallowed at the door so they never occupy a slot
    assign push    = b_valid & b_ready & (b_addr != 5'd0);
    assign head    = mem[rd_ptr];

    always_comb begin
        rf_wr_en     = 1'b0;
        rf_jal       = 1'b0;
        rf_wr_addr   = 5'd0;
        rf_wr_data   = 32'd0;
        rf_link_addr = 32'd0;
        if (grant_a) begin
            rf_wr_en     = 1'b1;
            rf_jal       = a_link;
            rf_wr_addr   = a_addr;
            rf_wr_data   = a_data;
            rf_link_addr = a_data;
        end else if (grant_b) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = head.addr;
            rf_wr_data = head.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cnt    <= '0;
            state  <= ST_NORMAL;
        end else begin
            if (push)    wr_ptr <= wr_ptr + PW'(1);
            if (grant_b) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(grant_b);
            if (grant_b || empty) begin
                cnt   <= '0;
                state <= ST_NORMAL;
            end else if (grant_a) begin
                cnt <= cnt + SW'(1);
                if (cnt + SW'(1) == SW'(STARVE_LIMIT)) state <= ST_FORCE;
            end
        end
    end

    // Payload storage needs no reset: slot liveness comes from rd_ptr/count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {b_addr, b_data};
    end

    logic [DEPTH-1:0] hit0, hit1;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PW-1:0] off;
        logic          live;
        assign off     = PW'(i) - rd_ptr;
        assign live    = ({1'b0, off} < count);
        assign hit0[i] = live & (mem[i].addr == chk_addr0);
        assign hit1[i] = live & (mem[i].addr == chk_addr1);
    end

    assign hazard0 = rst & (chk_addr0 != 5'd0) & (|hit0);
    assign hazard1 = rst & (chk_addr1 != 5'd0) & (|hit1);

endmodule
